// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial ALU blocks: controller state
// encoding and the default operand width.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Controller states; the encoding is fixed so other serial ALU
    // blocks can share it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// 1-bit full subtractor: diff = i1 - i2 - i3, borrow out in borrow.
module full_subtractor (
    input  logic i1,
    input  logic i2,
    input  logic i3,
    output logic diff,
    output logic borrow
);

    // Difference bit and borrow-out of a single bit position.
    always_comb begin
        diff   = i1 ^ i2 ^ i3;
        borrow = (~i1 & i2) | (~(i1 ^ i2) & i3);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// one bit per clock through a single reused full subtractor.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    serial_state_t    state;
    serial_state_t    state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] diff_sr;
    logic [CW-1:0]    count;
    logic             borrow;

    logic             d_bit;
    logic             b_bit;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] diff_next;

    full_subtractor u_fs (
        .i1     (a_sr[0]),
        .i2     (b_sr[0]),
        .i3     (borrow),
        .diff   (d_bit),
        .borrow (b_bit)
    );

    // Partial difference (upper WIDTH-1 bits) extended by the current bit;
    // on the last edge this is the complete result.
    always_comb begin
        diff_next = {d_bit, diff_sr};
        accept    = start && (state != SHIFT);
        last      = (state == SHIFT) && (count == LAST);
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == LAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            diff_sr  <= '0;
            count    <= '0;
            borrow   <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= b;
            borrow  <= bin;
            count   <= '0;
            diff_sr <= '0;
            diff    <= '0;
        end else if (state == SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            borrow  <= b_bit;
            count   <= count + CW'(1);
            diff_sr <= diff_next[WIDTH-1:1];
            if (last) begin
                diff     <= diff_next;
                bout     <= b_bit;
                // borrow here is the borrow into the MSB position
                overflow <= borrow ^ b_bit;
            end
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor; computes diff = a - b - bin one bit per clock, LSB first.
- Built around a single 1-bit full subtractor that is reused every cycle, plus a borrow flip-flop.
- Sits in the ALU beside the full-adder datapath. Serves area-constrained paths where a WIDTH-cycle latency is acceptable.
- Start/done handshake. Results are held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request pulse; sampled only when not busy.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- bin  input  1  borrow-in; captured on the accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: results valid from this cycle onward.
- diff  output  WIDTH  difference, mod 2^WIDTH.
- bout  output  1  unsigned borrow-out; 1 iff a < b + bin (unsigned).
- overflow  output  1  signed overflow of a - b - bin.

Behaviour:
- One clock domain (clk). rst is synchronous, active-high and overrides everything else.
- Reset values: busy=0, done=0, diff=0, bout=0, overflow=0, state=IDLE, bit counter=0, internal borrow=0.
- States:
  - IDLE: waiting for start.
  - SHIFT: WIDTH processing cycles.
  - DONE: one cycle.
- IDLE or DONE, start=1 at edge T:
  - Latch a and b into shift registers and bin into the borrow FF.
  - Clear the counter and the diff register; go to SHIFT.
  - busy=1 from cycle T+1.
- IDLE or DONE, start=0: stay in IDLE (DONE always goes to IDLE). done=0 outside DONE.
- SHIFT, each edge:
  - The full subtractor takes a_sr[0], b_sr[0] and the borrow FF.
  - d_i shifts into diff from the MSB side; a_sr and b_sr shift right; the borrow FF takes b_o; the counter increments.
  - Bit WIDTH-1's borrow-in is also captured for the overflow calculation.
- After WIDTH SHIFT edges (counter == WIDTH-1 at the edge):
  - Go to DONE; busy=0, done=1.
  - bout = final borrow.
  - overflow = borrow-into-MSB XOR borrow-out-of-MSB.
- Latency: start accepted at edge T → done high in the cycle after edge T+WIDTH (WIDTH+1 edges after the start edge).
- diff, bout and overflow change only at the final SHIFT edge, at an accepted start (diff cleared), or at reset. Otherwise they hold indefinitely.
- start while busy: ignored. No queueing, operands unchanged, the running operation completes normally.
- start in the DONE cycle: accepted. Back-to-back operations are allowed, and done stays a single-cycle pulse.
- a, b and bin may change freely after the start edge; only the captured copies are used.
- rst mid-operation: abort immediately to IDLE with reset values. No done pulse for the aborted operation.
- Counter width: clog2(WIDTH)+1 bits; no wrap-around within an operation.
- Full-subtractor equations:
  - d = x ^ y ^ b_i
  - b_o = (~x & y) | (~(x ^ y) & b_i)

Decomposition:
- Shared ALU include file holds the state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2). Future serial ALU blocks reuse it.
- One natural sub-module: full_subtractor (ports diff, borrow, i1, i2, i3). It is purely combinational and instantiated once.
- FSM, shift registers, counter and result registers live in serial_subtractor.

Test Plan:
- WIDTH=8; a=0x50, b=0x20, bin=0, start pulse → done exactly 9 edges after the start edge; diff=0x30, bout=0, overflow=0; busy high for 8 cycles.
- a=0x20, b=0x50, bin=0 → diff=0xD0, bout=1, overflow=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, overflow=1. Also a=0x7F, b=0xFF → diff=0x80, bout=1, overflow=1.
- a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1, overflow=0. Then start in the DONE cycle with a=0x05, b=0x03 → the second done 9 edges later with diff=0x02, and the first results held until then.
- Start with a=0x10, b=0x01. Pulse start with a=0xFF, b=0xFF on cycle 3 → ignored; result diff=0x0F. Change the a/b inputs mid-operation → no effect.
- Assert rst at the 4th SHIFT cycle → next cycle busy=0, done=0, diff=0, bout=0, overflow=0, no done pulse. A new start afterwards completes correctly.
